// File: rtl/lif_uart_pkg.sv
`timescale 1ns/1ps
// lif_uart_pkg: shared definitions for the LIF board UART (8N1, LSB first).
// The frame constants are common to the transmitter and the receiver so both
// ends of the link agree on the frame layout.
package lif_uart_pkg;

  // Receiver FSM encoding; the values are fixed so waveforms read the same
  // across builds.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // 12 MHz fabric clock / 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 104;

  // Frame layout shared with the transmitter.
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

endpackage : lif_uart_pkg

// File: rtl/lif_uart_sync.sv
`timescale 1ns/1ps
// lif_uart_sync: brings the asynchronous rx pin into the clk domain and flags
// its falling edges.
//   rx_s : 2-FF synchronised line level.
//   fall : high for one cycle when the synchronised line went 1 -> 0.
// All flops reset to 1 so that reset release on an idle line never looks like
// a start edge.
module lif_uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic meta;
  logic rx_s_d;

  // Two-stage synchroniser followed by a one-cycle delayed copy for edge detection.
  // NOTE: clocked state uses non-blocking assignments so every flop samples the
  // value from before the edge; blocking here would collapse the chain to one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      meta   <= rx;
      rx_s   <= meta;
      rx_s_d <= rx_s;
    end
  end

  // A start edge is a synchronised high followed by a synchronised low.
  assign fall = rx_s_d & ~rx_s;

endmodule : lif_uart_sync

// File: rtl/lif_uart_rx.sv
`timescale 1ns/1ps
// lif_uart_rx: 8N1 UART receiver for the LIF neuron uart_tx stream.
//
// The start bit is confirmed at its midpoint, then every following bit is
// sampled one full bit period later, so each data and stop sample lands in the
// centre of its bit. The FSM returns to IDLE at the stop-bit midpoint so a
// following start edge that arrives half a bit later is not missed.
//
// Received bytes go into a single-entry valid/ready holding register. A byte
// completing while the register is full and not being drained is dropped and
// reported on overrun; a low stop bit drops the byte and reports frame_err.
// Both error outputs are registered one-cycle pulses aligned with the cycle in
// which rx_valid/rx_data would have updated.
module lif_uart_rx
  import lif_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int IDX_W    = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  rx_state_t            state;
  rx_state_t            state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shift;

  logic rx_s;
  logic fall;

  logic tick;        // current state's sample point is this cycle
  logic sample_bit;  // capture rx_s into the shift register
  logic byte_done;   // stop bit sampled high: a good byte is complete
  logic stop_bad;    // stop bit sampled low: framing error

  lif_uart_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  // FSM state register; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  // NOTE: every variable driven from always_comb gets a default on entry, so
  // no path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        // Only a 1->0 edge starts a frame; a line stuck low stays here.
        if (fall) state_nxt = START;
      end
      START: begin
        // A start bit that is already high again at its midpoint was a glitch.
        if (cnt == HALF_LAST) state_nxt = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (cnt == BIT_LAST && idx == IDX_LAST) state_nxt = STOP;
      end
      STOP: begin
        // Leave at the stop-bit midpoint to be ready for a back-to-back frame.
        if (cnt == BIT_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM output decode: busy flag and the per-state sample strobes.
  always_comb begin
    busy = (state != IDLE);
    tick = 1'b0;
    unique case (state)
      START:       tick = (cnt == HALF_LAST);
      DATA, STOP:  tick = (cnt == BIT_LAST);
      default:     tick = 1'b0;
    endcase
    sample_bit = (state == DATA) && tick;
    byte_done  = (state == STOP) && tick && rx_s;
    stop_bad   = (state == STOP) && tick && !rx_s;
  end

  // Bit timer, bit index and LSB-first shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      // The timer restarts at every sample point and is held at zero while
      // idle, so it never needs to wrap.
      if (state == IDLE || tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (state == START) begin
        idx <= '0;
      end else if (sample_bit) begin
        shift[idx] <= rx_s;
        idx        <= idx + 1'b1;
      end
    end
  end

  // Holding register and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      // A byte that arrives in the same cycle the old one is drained is not
      // an overrun: the drain frees the slot for it.
      overrun   <= byte_done && rx_valid && !rx_ready;

      if (byte_done && (!rx_valid || rx_ready)) begin
        // Load wins over the clear from a simultaneous handshake.
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule : lif_uart_rx
